pipe_seq: RTL and testbench

Parametrised pipeline sequencer for the bf8b core. It replaces hand-wired stage start/stop logic with a registered controller for an N-stage in-order pipeline. The controller issues load pulses and enables to every stage and owns the fetch PC. A register scoreboard stalls the issue stage on read-after-write hazards. Redirect flushes discard younger stages. Stages keep their own datapath registers and capture them on `stage_load`.

---
 rtl/pipe_seq.sv | 115 +++++++++++
 tb/tb_pipe_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_seq.sv
// pipe_seq: registered start/stop controller for an N-stage in-order pipeline.
// Owns the fetch PC and a register scoreboard that holds the issue stage on RAW hazards.
module pipe_seq #(
   parameter int M_WIDTH  = 32,
   parameter int REG_CNT  = 32,
   parameter int STAGES   = 4,
   parameter int ISSUE    = 2,
   parameter int PC_STEP  = 4,
   parameter logic [M_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [STAGES-1:0]          stage_ready,
   output logic [STAGES-1:0]          stage_en,
   output logic [STAGES-1:0]          stage_load,
   output logic [M_WIDTH-1:0]         pc,
   input  logic [$clog2(REG_CNT)-1:0] issue_rs1,
   input  logic [$clog2(REG_CNT)-1:0] issue_rs2,
   input  logic [$clog2(REG_CNT)-1:0] issue_rd,
   input  logic                       issue_rd_we,
   input  logic                       retire_valid,
   input  logic [$clog2(REG_CNT)-1:0] retire_rd,
   input  logic                       flush_valid,
   input  logic [M_WIDTH-1:0]         flush_pc,
   output logic                       stall,
   output logic [REG_CNT-1:0]         sb_busy
);

   logic [STAGES-1:0]  stage_en_reg, stage_en_next;
   logic [M_WIDTH-1:0] pc_reg, pc_next;
   logic [REG_CNT-1:0] sb_busy_reg, sb_busy_next;

   // prev_done[k] is done[k-1]; fetch has nothing upstream so its slot is always true.
   logic [STAGES-1:0]  prev_done;
   // adv_ext[STAGES] stands for the writeback exit so every stage sees adv_ext[k+1] as adv_out.
   logic [STAGES:0]    adv_ext;
   logic [STAGES-1:0]  free_vec;
   logic               rs1_busy, rs2_busy, hazard;

   genvar gi;

   assign prev_done[0] = 1'b1;
   generate
      for (gi = 1; gi < STAGES; gi++) begin : g_done
         assign prev_done[gi] = stage_en_reg[gi-1] & stage_ready[gi-1];
      end
   endgenerate

   // A retire in this same cycle releases the register early.
   assign rs1_busy = (issue_rs1 != '0) && sb_busy_reg[issue_rs1]
                     && !(retire_valid && (retire_rd == issue_rs1));
   assign rs2_busy = (issue_rs2 != '0) && sb_busy_reg[issue_rs2]
                     && !(retire_valid && (retire_rd == issue_rs2));
   assign hazard   = rs1_busy | rs2_busy;

   // Advance chain is resolved from writeback back to fetch.
   always_comb begin
      adv_ext          = '0;
      free_vec         = '0;
      adv_ext[STAGES]  = stage_ready[STAGES-1];
      for (int k = STAGES - 1; k >= 0; k--) begin
         free_vec[k] = !stage_en_reg[k] | adv_ext[k+1];
         adv_ext[k]  = prev_done[k] & free_vec[k];
         if (k == ISSUE) begin
            adv_ext[k] = adv_ext[k] & !hazard;
         end
         if (k <= ISSUE) begin
            adv_ext[k] = adv_ext[k] & !flush_valid;
         end
      end
   end

   always_comb begin
      stage_en_next = adv_ext[STAGES-1:0] | (stage_en_reg & ~adv_ext[STAGES:1]);
      if (flush_valid) begin
         stage_en_next[ISSUE-1:0] = '0;
      end

      pc_next = pc_reg;
      if (flush_valid) begin
         pc_next = flush_pc;
      end else if (adv_ext[0]) begin
         pc_next = pc_reg + M_WIDTH'(PC_STEP);
      end

      // A set issued this cycle wins over a retire of the same register.
      sb_busy_next = sb_busy_reg;
      if (retire_valid) begin
         sb_busy_next[retire_rd] = 1'b0;
      end
      if (adv_ext[ISSUE] && issue_rd_we && (issue_rd != '0)) begin
         sb_busy_next[issue_rd] = 1'b1;
      end
      sb_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_en_reg <= '0;
         pc_reg       <= RESET_PC;
         sb_busy_reg  <= '0;
      end else begin
         stage_en_reg <= stage_en_next;
         pc_reg       <= pc_next;
         sb_busy_reg  <= sb_busy_next;
      end
   end

   assign stage_en   = stage_en_reg;
   assign stage_load = adv_ext[STAGES-1:0];
   assign pc         = pc_reg;
   assign sb_busy    = sb_busy_reg;
   assign stall      = prev_done[ISSUE] & free_vec[ISSUE] & hazard;

endmodule

// File: tb/tb_pipe_seq.sv
// Self-checking bench for pipe_seq: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an instruction-movement model of the pipeline.
module tb_pipe_seq;

   localparam int S  = 4;
   localparam int I  = 2;
   localparam int RC = 32;
   localparam int RW = 5;
   localparam int MW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [S-1:0]  stage_ready;
   logic [S-1:0]  stage_en;
   logic [S-1:0]  stage_load;
   logic [MW-1:0] pc;
   logic [RW-1:0] issue_rs1, issue_rs2, issue_rd;
   logic          issue_rd_we;
   logic          retire_valid;
   logic [RW-1:0] retire_rd;
   logic          flush_valid;
   logic [MW-1:0] flush_pc;
   logic          stall;
   logic [RC-1:0] sb_busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   pipe_seq #(
      .M_WIDTH(MW), .REG_CNT(RC), .STAGES(S), .ISSUE(I), .PC_STEP(4), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .stage_ready(stage_ready), .stage_en(stage_en),
      .stage_load(stage_load), .pc(pc), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .retire_valid(retire_valid),
      .retire_rd(retire_rd), .flush_valid(flush_valid), .flush_pc(flush_pc),
      .stall(stall), .sb_busy(sb_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 50)
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model: pipeline as a row of occupied slots ----------------
   bit            m_occ[S];
   bit            m_move[S];   // occupant of slot k moves on to slot k+1
   bit            m_room[S];
   bit            m_exit, m_fetch, m_haz, m_stall;
   logic [RC-1:0] m_sb;
   logic [MW-1:0] m_pc;
   int            m_fetched, m_retired;
   int            dut_loads, dut_retires;

   task automatic model_reset();
      for (int k = 0; k < S; k++) m_occ[k] = 0;
      m_sb = '0;
      m_pc = '0;
      m_fetched = 0;
      m_retired = 0;
      dut_loads = 0;
      dut_retires = 0;
   endtask

   function automatic bit reg_pending(input logic [RW-1:0] r);
      if (r == 0) return 0;
      if (retire_valid && retire_rd == r) return 0;
      return m_sb[r];
   endfunction

   task automatic model_eval();
      bit mv;
      m_haz  = reg_pending(issue_rs1) || reg_pending(issue_rs2);
      m_exit = m_occ[S-1] && stage_ready[S-1];
      m_room[S-1] = !m_occ[S-1] || m_exit;
      m_move[S-1] = 0;
      for (int k = S - 2; k >= 0; k--) begin
         mv = m_occ[k] && stage_ready[k] && m_room[k+1];
         if (k + 1 == I) mv = mv && !m_haz;
         if (k + 1 <= I) mv = mv && !flush_valid;
         m_move[k] = mv;
         m_room[k] = !m_occ[k] || mv;
      end
      m_fetch = m_room[0] && !flush_valid;
      m_stall = m_occ[I-1] && stage_ready[I-1] && m_room[I] && m_haz;
   endtask

   function automatic logic [S-1:0] m_en_vec();
      logic [S-1:0] v;
      for (int k = 0; k < S; k++) v[k] = m_occ[k];
      return v;
   endfunction

   function automatic logic [S-1:0] m_load_vec();
      logic [S-1:0] v;
      v[0] = m_fetch;
      for (int k = 1; k < S; k++) v[k] = m_move[k-1];
      return v;
   endfunction

   task automatic model_update();
      logic [S-1:0] ld;
      ld = m_load_vec();
      if (m_exit) m_retired++;
      if (m_fetch) m_fetched++;
      for (int k = S - 1; k >= 1; k--) begin
         if (m_move[k-1]) m_occ[k] = 1;
         else if ((k == S - 1) ? m_exit : m_move[k]) m_occ[k] = 0;
      end
      if (m_fetch) m_occ[0] = 1;
      else if (m_move[0]) m_occ[0] = 0;
      if (flush_valid) for (int k = 0; k < I; k++) m_occ[k] = 0;
      if (retire_valid) m_sb[retire_rd] = 1'b0;
      if (ld[I] && issue_rd_we && issue_rd != 0) m_sb[issue_rd] = 1'b1;
      m_sb[0] = 1'b0;
      if (flush_valid) m_pc = flush_pc;
      else if (m_fetch) m_pc = m_pc + 32'd4;
   endtask

   // Inputs are already driven; compare mid-cycle, then step the model with the edge.
   task automatic run_cycle(input string tag);
      model_eval();
      @(negedge clk);
      chk({tag, ".en"},    stage_en,   m_en_vec());
      chk({tag, ".load"},  stage_load, m_load_vec());
      chk({tag, ".pc"},    pc,         m_pc);
      chk({tag, ".stall"}, stall,      m_stall);
      chk({tag, ".sb"},    sb_busy,    m_sb);
      if (stage_load[0]) dut_loads++;
      if (stage_en[S-1] && stage_ready[S-1]) dut_retires++;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      stage_ready = '1;
      issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_rd_we = 1'b0;
      retire_valid = 1'b0; retire_rd = '0;
      flush_valid = 1'b0; flush_pc = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [S-1:0]  ready;
      logic [RW-1:0] rs1, rs2, rd;
      logic          we, rv;
      logic [RW-1:0] rrd;
      logic          fv;
      logic [MW-1:0] fpc;
      logic [S-1:0]  e_en, e_load;
      logic [MW-1:0] e_pc;
      logic          e_stall;
      logic [RC-1:0] e_sb;
   } vec_t;

   vec_t tv[13];

   function automatic vec_t mk(input logic [S-1:0] ready, input int rs1, input int rs2,
                               input int rd, input bit we, input bit rv, input int rrd,
                               input bit fv, input logic [MW-1:0] fpc,
                               input logic [S-1:0] e_en, input logic [S-1:0] e_load,
                               input logic [MW-1:0] e_pc, input bit e_stall,
                               input logic [RC-1:0] e_sb);
      vec_t v;
      v.ready = ready; v.rs1 = RW'(rs1); v.rs2 = RW'(rs2); v.rd = RW'(rd); v.we = we;
      v.rv = rv; v.rrd = RW'(rrd); v.fv = fv; v.fpc = fpc;
      v.e_en = e_en; v.e_load = e_load; v.e_pc = e_pc; v.e_stall = e_stall; v.e_sb = e_sb;
      return v;
   endfunction

   initial begin
      //            ready  rs1 rs2 rd we rv rrd fv fpc        en     load   pc      st sb
      tv[0]  = mk(4'hF, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'h0, 4'h1, 32'd0,  0, 32'h0);
      tv[1]  = mk(4'hF, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'h1, 4'h3, 32'd4,  0, 32'h0);
      tv[2]  = mk(4'hF, 0, 0, 5, 1, 0, 0, 0, 32'h0,   4'h3, 4'h7, 32'd8,  0, 32'h0);
      tv[3]  = mk(4'hF, 5, 0, 6, 1, 0, 0, 0, 32'h0,   4'h7, 4'h8, 32'd12, 1, 32'h20);
      tv[4]  = mk(4'hF, 5, 0, 6, 1, 0, 0, 0, 32'h0,   4'hB, 4'h0, 32'd12, 1, 32'h20);
      tv[5]  = mk(4'hF, 5, 0, 6, 1, 1, 5, 0, 32'h0,   4'h3, 4'h7, 32'd12, 0, 32'h20);
      tv[6]  = mk(4'hF, 0, 0, 0, 1, 0, 0, 0, 32'h0,   4'h7, 4'hF, 32'd16, 0, 32'h40);
      tv[7]  = mk(4'hF, 0, 0, 0, 1, 0, 0, 0, 32'h0,   4'hF, 4'hF, 32'd20, 0, 32'h40);
      tv[8]  = mk(4'hF, 0, 6, 0, 0, 0, 0, 0, 32'h0,   4'hF, 4'h8, 32'd24, 1, 32'h40);
      tv[9]  = mk(4'hF, 0, 6, 6, 1, 1, 6, 0, 32'h0,   4'hB, 4'h7, 32'd24, 0, 32'h40);
      tv[10] = mk(4'hF, 0, 0, 0, 0, 0, 0, 1, 32'h100, 4'h7, 4'h8, 32'd28, 0, 32'h40);
      tv[11] = mk(4'hF, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'h8, 4'h1, 32'h100, 0, 32'h40);
      tv[12] = mk(4'h7, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4'h1, 4'h3, 32'h104, 0, 32'h40);

      rst = 1'b0;
      apply_reset();

      for (int i = 0; i < 13; i++) begin
         stage_ready = tv[i].ready;
         issue_rs1 = tv[i].rs1; issue_rs2 = tv[i].rs2;
         issue_rd = tv[i].rd; issue_rd_we = tv[i].we;
         retire_valid = tv[i].rv; retire_rd = tv[i].rrd;
         flush_valid = tv[i].fv; flush_pc = tv[i].fpc;
         @(negedge clk);
         chk("vec.en",    stage_en,   tv[i].e_en);
         chk("vec.load",  stage_load, tv[i].e_load);
         chk("vec.pc",    pc,         tv[i].e_pc);
         chk("vec.stall", stall,      tv[i].e_stall);
         chk("vec.sb",    sb_busy,    tv[i].e_sb);
         $display("vec %0d: en=%b load=%b pc=0x%0h stall=%b sb=0x%0h",
                  i, stage_en, stage_load, pc, stall, sb_busy);
         @(posedge clk);
         #1;
      end

      // Back-pressure at writeback: pipeline freezes full, then drains without loss.
      apply_reset();
      repeat (6) run_cycle("bp_fill");
      stage_ready = 4'b0111;
      for (int i = 0; i < 5; i++) begin
         run_cycle("bp_hold");
         chk("bp_hold.en_full", stage_en, 4'hF);
         chk("bp_hold.pc_frozen", pc, 32'd24);
      end
      stage_ready = 4'hF;
      repeat (8) run_cycle("bp_release");
      chk("bp.load_count", dut_loads, m_fetched);
      chk("bp.retire_count", dut_retires, m_retired);
      $display("backpressure: loads=%0d retires=%0d", dut_loads, dut_retires);

      // Asynchronous reset between edges with scoreboard and pipeline populated.
      apply_reset();
      issue_rd = 5'd9; issue_rd_we = 1'b1;
      repeat (5) run_cycle("ar_run");
      chk("ar.sb_set", sb_busy[9], 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar.en",   stage_en,   4'h0);
      chk("ar.pc",   pc,         32'h0);
      chk("ar.sb",   sb_busy,    32'h0);
      chk("ar.load", stage_load, 4'h1);
      $display("async reset: en=%b pc=0x%0h sb=0x%0h", stage_en, pc, sb_busy);
      apply_reset();

      // PC wrap-around after a redirect to the top of the address space.
      flush_valid = 1'b1; flush_pc = 32'hFFFF_FFFC;
      run_cycle("wrap_flush");
      chk("wrap.pc_top", pc, 32'hFFFF_FFFC);
      flush_valid = 1'b0;
      run_cycle("wrap_step");
      chk("wrap.pc_zero", pc, 32'h0);
      $display("pc wrap: pc=0x%0h", pc);

      // Randomized traffic against the model, including an occasional flush.
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < S; k++) stage_ready[k] = ($urandom_range(0, 3) != 0);
         issue_rs1 = RW'($urandom_range(0, 7));
         issue_rs2 = RW'($urandom_range(0, 7));
         issue_rd = RW'($urandom_range(0, 7));
         issue_rd_we = 1'($urandom_range(0, 1));
         retire_valid = ($urandom_range(0, 2) == 0);
         retire_rd = RW'($urandom_range(0, 7));
         flush_valid = ($urandom_range(0, 19) == 0);
         flush_pc = $urandom;
         run_cycle("rnd");
      end
      chk("rnd.load_count", dut_loads, m_fetched);
      chk("rnd.retire_count", dut_retires, m_retired);
      $display("random: fetched=%0d retired=%0d", m_fetched, m_retired);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
